// File: rtl/control_unit_pkg.sv
// Shared types and constants for the control_unit memory target.
package control_unit_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    localparam int ERR_MISALIGN = 0;
    localparam int ERR_OOR      = 1;
    localparam int ERR_CONFLICT = 2;

    localparam int MEM_ADDR_W = 17;
    localparam int MEM_DATA_W = 32;
    localparam int IDX_W      = MEM_ADDR_W - 2;

    function automatic logic out_of_range(
        input logic [IDX_W-1:0] idx,
        input int unsigned      words
    );
        return 32'(idx) >= words;
    endfunction

endpackage

// File: rtl/cu_word_ram.sv
// Single-port synchronous word RAM with registered read data.
import control_unit_pkg::*;

module cu_word_ram #(
    parameter int WORDS = 128,
    parameter int AW    = $clog2(WORDS)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [AW-1:0]         addr,
    input  logic [MEM_DATA_W-1:0] wdata,
    output logic [MEM_DATA_W-1:0] rdata
);

    logic [MEM_DATA_W-1:0] mem [WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/control_unit_memory.sv
// Wait-stated word memory serving control_unit, with a host load/inspect port.
import control_unit_pkg::*;

module control_unit_memory #(
    parameter int          MEM_WORDS   = 128,
    parameter int          WAIT_STATES = 2,
    parameter logic [31:0] OOR_DATA    = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_read_req,
    input  logic        mem_write_req,
    input  logic [16:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        mem_busy,
    input  logic        host_we,
    input  logic        host_re,
    input  logic [14:0] host_addr,
    input  logic [31:0] host_wdata,
    output logic [31:0] host_rdata,
    output logic        host_rvalid,
    output logic [2:0]  err_status,
    input  logic        err_clr
);

    localparam int AW = $clog2(MEM_WORDS);
    localparam logic [3:0] WAIT_LAST =
        (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    state_t state;
    state_t state_nx;
    logic [3:0] cnt;
    logic [3:0] cnt_nx;

    logic          op_wr;
    logic [AW-1:0] idx;
    logic [31:0]   wdata_q;
    logic          oor_q;

    logic          host_oor_q;
    logic [31:0]   host_hold;

    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_wdata;
    logic [31:0]   ram_rdata;

    logic [2:0]    err_nx;

    logic [14:0] req_idx;
    logic        in_idle;
    logic        host_any;
    logic        req_any;
    logic        req_both;
    logic        accept;
    logic        req_oor;
    logic        host_oor;

    assign req_idx  = mem_addr[16:2];
    assign in_idle  = (state == IDLE);
    assign host_any = host_we | host_re;
    assign req_any  = mem_read_req | mem_write_req;
    assign req_both = mem_read_req & mem_write_req;
    assign accept   = in_idle & req_any & ~req_both & ~host_any;
    assign req_oor  = out_of_range(req_idx, MEM_WORDS);
    assign host_oor = out_of_range(host_addr, MEM_WORDS);

    assign mem_busy = ~in_idle;

    // Host read data is live on the rvalid cycle, then held.
    assign host_rdata = host_rvalid
                      ? (host_oor_q ? OOR_DATA : ram_rdata)
                      : host_hold;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    cnt_nx = 4'd0;
                    if (WAIT_STATES == 0) begin
                        state_nx = RESP;
                    end else begin
                        state_nx = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt == WAIT_LAST) begin
                    state_nx = RESP;
                end else begin
                    cnt_nx = cnt + 4'd1;
                end
            end
            RESP: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // The RAM is addressed one cycle ahead so read data lands in RESP.
    always_comb begin
        ram_we    = 1'b0;
        ram_addr  = idx;
        ram_wdata = wdata_q;
        if (in_idle) begin
            if (host_any) begin
                ram_addr  = host_addr[AW-1:0];
                ram_wdata = host_wdata;
                ram_we    = host_we & ~host_oor;
            end else begin
                ram_addr = req_idx[AW-1:0];
            end
        end else if (state == RESP) begin
            ram_we = op_wr & ~oor_q;
        end
        if (reset) begin
            ram_we = 1'b0;
        end
    end

    always_comb begin
        err_nx = err_clr ? 3'b000 : err_status;
        if (in_idle && req_any && !host_any) begin
            if (req_both) begin
                err_nx[ERR_CONFLICT] = 1'b1;
            end else begin
                if (mem_addr[1:0] != 2'b00) begin
                    err_nx[ERR_MISALIGN] = 1'b1;
                end
                if (req_oor) begin
                    err_nx[ERR_OOR] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= 4'd0;
            op_wr       <= 1'b0;
            idx         <= '0;
            wdata_q     <= 32'd0;
            oor_q       <= 1'b0;
            mem_rdata   <= 32'd0;
            host_rvalid <= 1'b0;
            host_oor_q  <= 1'b0;
            host_hold   <= 32'd0;
            err_status  <= 3'b000;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            err_status <= err_nx;
            if (accept) begin
                op_wr   <= mem_write_req;
                idx     <= req_idx[AW-1:0];
                wdata_q <= mem_wdata;
                oor_q   <= req_oor;
            end
            if (state == RESP && !op_wr) begin
                mem_rdata <= oor_q ? OOR_DATA : ram_rdata;
            end
            host_rvalid <= in_idle & host_re & ~host_we;
            if (in_idle && host_re) begin
                host_oor_q <= host_oor;
            end
            if (host_rvalid) begin
                host_hold <= host_rdata;
            end
        end
    end

    cu_word_ram #(
        .WORDS (MEM_WORDS),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_control_unit_memory.sv
// Randomised self-checking bench for control_unit_memory (WS=2 and WS=0).
module tb_control_unit_memory;

    localparam int WORDS = 128;
    localparam int WS    = 2;
    localparam logic [31:0] Z_OOR = 32'hDEAD_BEEF;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        mem_read_req, mem_write_req;
    logic [16:0] mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic        mem_busy;
    logic        host_we, host_re;
    logic [14:0] host_addr;
    logic [31:0] host_wdata, host_rdata;
    logic        host_rvalid;
    logic [2:0]  err_status;
    logic        err_clr;

    logic        z_reset;
    logic        z_rd, z_wr;
    logic [16:0] z_addr;
    logic [31:0] z_wdata, z_rdata;
    logic        z_busy;
    logic        z_hwe, z_hre;
    logic [14:0] z_haddr;
    logic [31:0] z_hwdata, z_hrdata;
    logic        z_hrvalid;
    logic [2:0]  z_err;
    logic        z_clr;

    control_unit_memory #(
        .MEM_WORDS(WORDS), .WAIT_STATES(WS), .OOR_DATA(32'h0)
    ) dut (
        .clk(clk), .reset(reset),
        .mem_read_req(mem_read_req), .mem_write_req(mem_write_req),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_busy(mem_busy),
        .host_we(host_we), .host_re(host_re),
        .host_addr(host_addr), .host_wdata(host_wdata),
        .host_rdata(host_rdata), .host_rvalid(host_rvalid),
        .err_status(err_status), .err_clr(err_clr)
    );

    control_unit_memory #(
        .MEM_WORDS(WORDS), .WAIT_STATES(0), .OOR_DATA(Z_OOR)
    ) dut0 (
        .clk(clk), .reset(z_reset),
        .mem_read_req(z_rd), .mem_write_req(z_wr),
        .mem_addr(z_addr), .mem_wdata(z_wdata),
        .mem_rdata(z_rdata), .mem_busy(z_busy),
        .host_we(z_hwe), .host_re(z_hre),
        .host_addr(z_haddr), .host_wdata(z_hwdata),
        .host_rdata(z_hrdata), .host_rvalid(z_hrvalid),
        .err_status(z_err), .err_clr(z_clr)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] mm [WORDS];
    logic [2:0]  err_exp;
    logic [31:0] rdata_exp;

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        mem_read_req = 0; mem_write_req = 0;
        host_we = 0; host_re = 0; err_clr = 0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        err_exp = 3'b000;
        rdata_exp = 32'd0;
    endtask

    task automatic host_wr(input logic [14:0] ix, input logic [31:0] d);
        @(negedge clk);
        host_we = 1; host_addr = ix; host_wdata = d;
        @(negedge clk);
        host_we = 0;
        if (ix < WORDS) mm[ix] = d;
    endtask

    task automatic host_rd(input logic [14:0] ix, input string nm);
        logic [31:0] exp;
        exp = (ix < WORDS) ? mm[ix] : 32'h0;
        @(negedge clk);
        host_re = 1; host_addr = ix;
        @(negedge clk);
        host_re = 0;
        n_tests++;
        if (host_rvalid !== 1'b1 || host_rdata !== exp) begin
            n_fail++;
            $display("FAIL %s: rvalid=%b rdata=%h, want rvalid=1 rdata=%h",
                     nm, host_rvalid, host_rdata, exp);
        end
        @(negedge clk);
        n_tests++;
        if (host_rvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_pulse: rvalid=%b, want 0", nm, host_rvalid);
        end
    endtask

    task automatic cu_op(input bit wr, input logic [16:0] a,
                         input logic [31:0] d, input bit clr,
                         input string nm);
        int n;
        logic [14:0] ix;
        bit oor;
        @(negedge clk);
        mem_read_req = !wr; mem_write_req = wr;
        mem_addr = a; mem_wdata = d; err_clr = clr;
        @(negedge clk);
        mem_read_req = 0; mem_write_req = 0; err_clr = 0;
        ix = a[16:2];
        oor = (ix >= WORDS);
        if (clr) err_exp = 3'b000;
        if (a[1:0] != 2'b00) err_exp[0] = 1'b1;
        if (oor) err_exp[1] = 1'b1;
        if (wr) begin
            if (!oor) mm[ix] = d;
        end else begin
            rdata_exp = oor ? 32'h0 : mm[ix];
        end
        n = 0;
        while (mem_busy && n < 64) begin
            n++;
            @(negedge clk);
        end
        n_tests++;
        if (n != WS + 1) begin
            n_fail++;
            $display("FAIL %s_busy: busy cycles=%0d, want %0d", nm, n, WS + 1);
        end
        n_tests++;
        if (mem_rdata !== rdata_exp) begin
            n_fail++;
            $display("FAIL %s_rdata: got %h, want %h", nm, mem_rdata, rdata_exp);
        end
        n_tests++;
        if (err_status !== err_exp) begin
            n_fail++;
            $display("FAIL %s_err: got %b, want %b", nm, err_status, err_exp);
        end
    endtask

    task automatic clr_err(input string nm);
        @(negedge clk);
        err_clr = 1;
        @(negedge clk);
        err_clr = 0;
        err_exp = 3'b000;
        n_tests++;
        if (err_status !== 3'b000) begin
            n_fail++;
            $display("FAIL %s: err=%b, want 000", nm, err_status);
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++;
        if (mem_busy !== 0 || mem_rdata !== 0 || host_rdata !== 0 ||
            host_rvalid !== 0 || err_status !== 0) begin
            n_fail++;
            $display("FAIL reset: busy=%b rdata=%h hrdata=%h hrv=%b err=%b, want all 0",
                     mem_busy, mem_rdata, host_rdata, host_rvalid, err_status);
        end
        for (int i = 0; i < WORDS; i++) host_wr(15'(i), $urandom);
    endtask

    task automatic test_basic_read();
        for (int i = 0; i < 4; i++) host_wr(15'(i), 32'h1111_0000 + i);
        cu_op(0, 17'h0008, 32'h0, 0, "read8");
        n_tests++;
        if (mem_rdata !== 32'h1111_0002) begin
            n_fail++;
            $display("FAIL read8_const: got %h, want 11110002", mem_rdata);
        end
    endtask

    task automatic test_write_host_read();
        cu_op(1, 17'h0010, 32'hCAFE_F00D, 0, "write10");
        host_rd(15'd4, "hread4");
    endtask

    task automatic test_oor();
        cu_op(0, 17'h0201, 32'h0, 0, "read_oor");
        clr_err("clr_oor");
        cu_op(0, 17'h0005, 32'h0, 0, "read_mis");
        cu_op(0, 17'h0007, 32'h0, 1, "clr_and_set");
        host_wr(15'd200, 32'h5555_AAAA);
        host_rd(15'd200, "hread_oor");
        clr_err("clr_mis");
    endtask

    task automatic test_conflict();
        @(negedge clk);
        mem_read_req = 1; mem_write_req = 1;
        mem_addr = 17'h001C; mem_wdata = ~mm[7];
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_tests++;
            if (mem_busy !== 1'b0) begin
                n_fail++;
                $display("FAIL conflict_busy: busy=%b, want 0", mem_busy);
            end
        end
        mem_read_req = 0; mem_write_req = 0;
        err_exp[2] = 1'b1;
        n_tests++;
        if (err_status !== err_exp) begin
            n_fail++;
            $display("FAIL conflict_err: got %b, want %b", err_status, err_exp);
        end
        host_rd(15'd7, "conflict_ram");
        clr_err("clr_conflict");
    endtask

    task automatic test_host_priority();
        int n;
        logic [31:0] d;
        d = $urandom;
        @(negedge clk);
        host_we = 1; host_addr = 15'd6; host_wdata = d;
        mem_read_req = 1; mem_addr = 17'h0018;
        @(negedge clk);
        host_we = 0;
        mm[6] = d;
        n_tests++;
        if (mem_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL prio_busy0: busy=%b, want 0", mem_busy);
        end
        @(negedge clk);
        mem_read_req = 0;
        n = 0;
        while (mem_busy && n < 64) begin
            n++;
            @(negedge clk);
        end
        n_tests++;
        if (n != WS + 1 || mem_rdata !== d) begin
            n_fail++;
            $display("FAIL prio_read: busy=%0d rdata=%h, want %0d %h",
                     n, mem_rdata, WS + 1, d);
        end
        rdata_exp = d;
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        mem_read_req = 1; mem_addr = 17'h000C;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            n_tests++;
            if (mem_busy !== ((k % (WS + 2)) != WS + 1)) begin
                n_fail++;
                $display("FAIL b2b_busy[%0d]: busy=%b, want %b",
                         k, mem_busy, (k % (WS + 2)) != WS + 1);
            end
        end
        mem_read_req = 0;
        rdata_exp = mm[3];
        n_tests++;
        if (mem_rdata !== rdata_exp) begin
            n_fail++;
            $display("FAIL b2b_rdata: got %h, want %h", mem_rdata, rdata_exp);
        end
    endtask

    task automatic test_reset_abort();
        logic [31:0] old;
        old = mm[5];
        @(negedge clk);
        mem_write_req = 1; mem_addr = 17'h0014; mem_wdata = ~old;
        @(negedge clk);
        mem_write_req = 0;
        @(negedge clk);
        reset = 1;
        @(negedge clk);
        reset = 0;
        err_exp = 3'b000;
        rdata_exp = 32'd0;
        n_tests++;
        if (mem_busy !== 1'b0 || mem_rdata !== 32'd0) begin
            n_fail++;
            $display("FAIL abort: busy=%b rdata=%h, want 0 0", mem_busy, mem_rdata);
        end
        host_rd(15'd5, "abort_ram");
    endtask

    task automatic test_random();
        int kind;
        logic [14:0] ix;
        logic [1:0] lo;
        for (int it = 0; it < 80; it++) begin
            kind = $urandom_range(0, 5);
            ix = 15'($urandom_range(0, WORDS + 15));
            lo = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            case (kind)
                0, 1: cu_op(0, {ix, lo}, 32'h0, 0, "rnd_read");
                2, 3: cu_op(1, {ix, lo}, $urandom, 0, "rnd_write");
                4:    host_wr(ix, $urandom);
                default: host_rd(ix, "rnd_hread");
            endcase
            if ((it % 16) == 15) clr_err("rnd_clr");
        end
    endtask

    task automatic test_zero_wait();
        int n;
        logic [31:0] d;
        d = $urandom;
        @(negedge clk);
        z_reset = 1;
        z_rd = 0; z_wr = 0; z_hwe = 0; z_hre = 0; z_clr = 0;
        repeat (2) @(negedge clk);
        z_reset = 0;
        z_hwe = 1; z_haddr = 15'd2; z_hwdata = d;
        @(negedge clk);
        z_hwe = 0;
        for (int t = 0; t < 2; t++) begin
            @(negedge clk);
            z_rd = 1; z_addr = (t == 0) ? 17'h0008 : 17'h0400;
            @(negedge clk);
            z_rd = 0;
            n = 0;
            while (z_busy && n < 64) begin
                n++;
                @(negedge clk);
            end
            n_tests++;
            if (n != 1 || z_rdata !== ((t == 0) ? d : Z_OOR)) begin
                n_fail++;
                $display("FAIL ws0_read%0d: busy=%0d rdata=%h, want 1 %h",
                         t, n, z_rdata, (t == 0) ? d : Z_OOR);
            end
        end
        @(negedge clk);
        z_hre = 1; z_haddr = 15'd300;
        @(negedge clk);
        z_hre = 0;
        n_tests++;
        if (z_hrvalid !== 1'b1 || z_hrdata !== Z_OOR || z_err !== 3'b010) begin
            n_fail++;
            $display("FAIL ws0_hread_oor: rv=%b rdata=%h err=%b, want 1 %h 010",
                     z_hrvalid, z_hrdata, z_err, Z_OOR);
        end
    endtask

    initial begin
        reset = 1; mem_read_req = 0; mem_write_req = 0;
        mem_addr = 0; mem_wdata = 0; host_we = 0; host_re = 0;
        host_addr = 0; host_wdata = 0; err_clr = 0;
        z_reset = 1; z_rd = 0; z_wr = 0; z_addr = 0; z_wdata = 0;
        z_hwe = 0; z_hre = 0; z_haddr = 0; z_hwdata = 0; z_clr = 0;
        err_exp = 0; rdata_exp = 0;
        test_reset();
        test_basic_read();
        test_write_host_read();
        test_oor();
        test_conflict();
        test_host_priority();
        test_back_to_back();
        test_reset_abort();
        test_random();
        test_zero_wait();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
